// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling from an internal bit-period counter.
// Define UART_RX_PARITY_EN for 8E1 frames with a PARITY state and parity_err reporting.
module uart_rx #(
    parameter int BAUD_CNT = 10416,
    parameter int BAUD_BIT = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    // state  | meaning
    // IDLE   | line idle, waiting for a falling edge on rx_s
    // START  | timing to mid start bit to reject glitches
    // DATA   | sampling 8 data bits at bit centre
    // PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
    // STOP   | sampling the stop bit, publishing the byte or flagging an error
    // BREAK  | line held low after a framing error, waiting for idle
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    localparam logic [BAUD_BIT-1:0] CNT_MID = BAUD_BIT'(BAUD_CNT / 2 - 1);
    localparam logic [BAUD_BIT-1:0] CNT_END = BAUD_BIT'(BAUD_CNT - 1);
    localparam logic [BAUD_BIT-1:0] CNT_ONE = BAUD_BIT'(1);

    state_t              state;
    logic [BAUD_BIT-1:0] cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shift;
    logic                rx_m;
    logic                rx_s;
`ifdef UART_RX_PARITY_EN
    logic                par_bit;
`else
    assign parity_err = 1'b0;
`endif

    // Flops reset high so reset release does not look like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            data      <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt == CNT_END) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_END) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (cnt == CNT_END) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (^shift ^ par_bit) begin
                                parity_err <= 1'b1;
                            end else begin
                                data    <= shift;
                                rx_done <= 1'b1;
                            end
`else
                            data    <= shift;
                            rx_done <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; honours UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int BC = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_NOM = 2 + BC / 2 + 10 * BC;
`else
    localparam int LAT_NOM = 2 + BC / 2 + 9 * BC;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_rx #(.BAUD_CNT(BC), .BAUD_BIT(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         done_cnt = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         ovl_cnt = 0;
    int         done_cyc = 0;
    int         rise_cyc = 0;
    int         hist_n = 0;
    logic       busy_q = 1'b0;
    logic [7:0] hist [0:31];

    always @(negedge clk) begin
        busy_q <= busy;
        if (busy && !busy_q) rise_cyc <= cyc;
        if (rx_done) begin
            done_cnt            <= done_cnt + 1;
            done_cyc            <= cyc;
            hist[hist_n[4:0]]   <= data;
            hist_n              <= hist_n + 1;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (parity_err) pe_cnt <= pe_cnt + 1;
        if (int'(rx_done) + int'(frame_err) + int'(parity_err) > 1) ovl_cnt <= ovl_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    // Called just after a rising edge; returns just after the last stop-bit cycle.
    task automatic send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        start_cyc = cyc;
        wait_cycles(BC);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(BC);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^b ^ par_flip;
        wait_cycles(BC);
`endif
        rx = stop;
        wait_cycles(BC);
    endtask

    int d0;
    int h0;
    int gs;
    int lat;
    int rise;
    logic [7:0] pb;

    initial begin
        wait_cycles(3);
        chk("rst_data", data, 8'h00);
        chk("rst_done", rx_done, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b1;
        wait_cycles(4);

        send(8'hA5, 1'b1);
        wait_cycles(4);
        lat  = done_cyc - start_cyc;
        rise = rise_cyc - start_cyc;
        chk("a5_data", data, 8'hA5);
        chk("a5_done_cnt", done_cnt, 1);
        chk("a5_latency", (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1), 1'b1);
        chk("a5_busy_rise", (rise >= 1 && rise <= 3), 1'b1);
        chk("a5_no_err", fe_cnt + pe_cnt, 0);
        chk("a5_busy_low", busy, 1'b0);

        d0 = done_cnt;
        gs = cyc;
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(14);
        chk("glitch_seen", (rise_cyc - gs >= 1 && rise_cyc - gs <= 3), 1'b1);
        chk("glitch_busy", busy, 1'b0);
        chk("glitch_done", done_cnt, d0);
        chk("glitch_data", data, 8'hA5);

        send(8'h3C, 1'b0);
        wait_cycles(40);
        chk("ferr_cnt", fe_cnt, 1);
        chk("ferr_data", data, 8'hA5);
        chk("ferr_done", done_cnt, d0);
        chk("break_busy", busy, 1'b1);
        rx = 1'b1;
        wait_cycles(5);
        chk("break_exit", busy, 1'b0);
        send(8'h81, 1'b1);
        wait_cycles(4);
        chk("after_break_data", data, 8'h81);
        chk("after_break_done", done_cnt, d0 + 1);

        d0 = done_cnt;
        h0 = hist_n;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h55, 1'b1);
        wait_cycles(4);
        chk("b2b_cnt", done_cnt, d0 + 3);
        chk("b2b_0", hist[(h0 + 0) % 32], 8'h00);
        chk("b2b_1", hist[(h0 + 1) % 32], 8'hFF);
        chk("b2b_2", hist[(h0 + 2) % 32], 8'h55);

        d0 = done_cnt;
        pb = 8'hC3;
        rx = 1'b0;
        wait_cycles(BC);
        for (int i = 0; i < 4; i++) begin
            rx = pb[i];
            wait_cycles(BC);
        end
        rx = pb[4];
        wait_cycles(8);
        rst = 1'b0;
        #1;
        chk("midrst_data", data, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", rx_done, 1'b0);
        chk("midrst_ferr", frame_err, 1'b0);
        wait_cycles(3);
        rx  = 1'b1;
        rst = 1'b1;
        wait_cycles(4);
        chk("midrst_no_done", done_cnt, d0);
        send(8'h7E, 1'b1);
        wait_cycles(4);
        chk("post_rst_data", data, 8'h7E);
        chk("post_rst_done", done_cnt, d0 + 1);

`ifdef UART_RX_PARITY_EN
        d0 = done_cnt;
        par_flip = 1'b1;
        send(8'h07, 1'b1);
        wait_cycles(4);
        chk("par_bad_perr", pe_cnt, 1);
        chk("par_bad_done", done_cnt, d0);
        chk("par_bad_data", data, 8'h7E);
        par_flip = 1'b0;
        send(8'h07, 1'b1);
        wait_cycles(4);
        chk("par_good_data", data, 8'h07);
        chk("par_good_done", done_cnt, d0 + 1);
        chk("par_good_perr", pe_cnt, 1);
`else
        chk("perr_never", pe_cnt, 0);
`endif

        chk("ferr_total", fe_cnt, 1);
        chk("pulse_overlap", ovl_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
